// File: rtl/counter_pkg.sv
// counter_pkg: shared types and defaults for the counter controller slice.
//   cmd_op_e      - 2-bit command opcode carried on cmd_op_i
//   ctrl_state_e  - controller FSM states
//   WIDTH_DEF     - default counter/data width
//   LEN_W_DEF     - default width of the RUN cycle-count field
//   WRAP_W        - width of the saturating wrap counter
package counter_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned WRAP_W    = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_RUN   = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

endpackage : counter_pkg

// File: rtl/counter_shadow.sv
// counter_shadow: shadow model of the counter plus a per-cycle consistency check.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enable, load    counter controls as driven by the controller
//   data            counter load value
//   count, even     values returned by the counter
//   err             sticky mismatch flag, cleared only by reset
module counter_shadow
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count,
  input  logic             even,
  output logic             err
);

  logic [WIDTH-1:0] shadow;
  logic             mismatch_c;

  // Both the counter and the shadow update on the same edge from the same
  // controls, so they must agree in every cycle.
  assign mismatch_c = (count != shadow) || (even != ~count[0]);

  // Shadow register follows the counter rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (enable && load) begin
      shadow <= data;
    end else if (enable) begin
      shadow <= shadow + WIDTH'(1);
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mismatch_c) begin
      err <= 1'b1;
    end
  end

endmodule : counter_shadow

// File: rtl/counter_ctrl.sv
// counter_ctrl: initiator side of counter_if. Accepts commands on a valid/ready
// port, drives enable/load/data of the counter, counts wrap-arounds of the
// returned count and, when COUNTER_CHECK_EN is defined, checks the counter
// against a shadow model (otherwise err_o is tied low).
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only in IDLE)
//   cmd_op_i/data_i/len_i     opcode, LOAD value, RUN cycle count
//   enable_o/load_o/data_o    counter controls (registered)
//   count_i/even_i            counter outputs
//   busy_o, done_o            not-idle flag, 1-cycle completion pulse
//   wrap_cnt_o                saturating wrap count
//   err_o                     sticky checker mismatch
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [WIDTH-1:0]  cmd_data_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              enable_o,
  output logic              load_o,
  output logic [WIDTH-1:0]  data_o,
  input  logic [WIDTH-1:0]  count_i,
  input  logic              even_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              err_o
);

  ctrl_state_e      state, state_d;
  cmd_op_e          op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] remain, remain_d;
  logic             enable_d, load_d, done_d, ready_d, busy_d;
  logic [WIDTH-1:0] dout_d;

  logic [WIDTH-1:0] prev_count;
  logic             prev_inc;
  logic             wrap_hit_c;

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      data_q      <= '0;
      remain      <= '0;
      enable_o    <= 1'b0;
      load_o      <= 1'b0;
      data_o      <= '0;
      done_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      remain      <= remain_d;
      enable_o    <= enable_d;
      load_o      <= load_d;
      data_o      <= dout_d;
      done_o      <= done_d;
      cmd_ready_o <= ready_d;
      busy_o      <= busy_d;
    end
  end

  // Next state, and output values decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    data_d   = data_q;
    remain_d = remain;
    enable_d = 1'b0;
    load_d   = 1'b0;
    dout_d   = '0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    busy_d   = 1'b1;

    case (state)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d   = cmd_op_e'(cmd_op_i);
          data_d = cmd_data_i;
          case (cmd_op_e'(cmd_op_i))
            OP_LOAD: begin
              state_d  = ST_DRIVE;
              remain_d = LEN_W'(1);
            end
            OP_CLEAR: begin
              state_d  = ST_DRIVE;
              remain_d = LEN_W'(1);
              data_d   = '0;
            end
            OP_RUN: begin
              remain_d = cmd_len_i;
              state_d  = (cmd_len_i == '0) ? ST_DONE : ST_DRIVE;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_DRIVE: begin
        remain_d = remain - LEN_W'(1);
        if (remain == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      ST_DRIVE: begin
        enable_d = 1'b1;
        load_d   = (op_d != OP_RUN);
        dout_d   = (op_d == OP_RUN) ? '0 : data_d;
      end
      ST_DONE: done_d = 1'b1;
      default: busy_d = 1'b1;
    endcase
  end

  // A wrap is all-ones -> zero following an increment-only cycle; loads of 0 never count.
  assign wrap_hit_c = prev_inc && (prev_count == '1) && (count_i == '0);

  // Wrap tracking with saturation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_count <= '0;
      prev_inc   <= 1'b0;
      wrap_cnt_o <= '0;
    end else begin
      prev_count <= count_i;
      prev_inc   <= enable_o && !load_o;
      if (wrap_hit_c && (wrap_cnt_o != '1)) begin
        wrap_cnt_o <= wrap_cnt_o + WRAP_W'(1);
      end
    end
  end

`ifdef COUNTER_CHECK_EN
  // Shadow checker against the counter.
  counter_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .enable (enable_o),
    .load   (load_o),
    .data   (data_o),
    .count  (count_i),
    .even   (even_i),
    .err    (err_o)
  );
`else
  logic unused_even;
  assign unused_even = even_i;
  assign err_o       = 1'b0;
`endif

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural 4-bit counter attached.
module tb_counter_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [LW-1:0] cmd_len;
  logic          enable, load;
  logic [W-1:0]  data;
  logic [W-1:0]  count;
  logic          even;
  logic          busy, done;
  logic [7:0]    wrap_cnt;
  logic          err;

  logic [W-1:0]  cnt_model;
  logic          force_en;
  logic [W-1:0]  force_val;

  int total = 0;
  int bad   = 0;
  int ref_count = 0;
  int ref_wraps = 0;
  logic exp_err = 1'b0;

  counter_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .cmd_len_i   (cmd_len),
    .enable_o    (enable),
    .load_o      (load),
    .data_o      (data),
    .count_i     (count),
    .even_i      (even),
    .busy_o      (busy),
    .done_o      (done),
    .wrap_cnt_o  (wrap_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // The counter being controlled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_model <= '0;
    else if (enable && load) cnt_model <= data;
    else if (enable) cnt_model <= cnt_model + 4'd1;
  end
  assign count = force_en ? force_val : cnt_model;
  assign even  = ~count[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 32'(cmd_ready), 1);
    check({tag, ".busy"},  32'(busy), 0);
    check({tag, ".done"},  32'(done), 0);
    check({tag, ".en"},    32'(enable), 0);
    check({tag, ".wrap"},  32'(wrap_cnt), 32'(ref_wraps));
    check({tag, ".err"},   32'(err), 32'(exp_err));
  endtask

  // Reference: effect of a completed command on counter value and wrap count.
  task automatic ref_apply(input logic [1:0] op, input logic [W-1:0] d, input logic [LW-1:0] len);
    case (op)
      2'd1: ref_count = int'(d);
      2'd3: ref_count = 0;
      2'd2: begin
        ref_wraps = ref_wraps + (ref_count + int'(len)) / 16;
        if (ref_wraps > 255) ref_wraps = 255;
        ref_count = (ref_count + int'(len)) % 16;
      end
      default: ;
    endcase
  endtask

  task automatic drive_cycles(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                              input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, ".drv_en"},   32'(enable), 1);
      check({tag, ".drv_ld"},   32'(load), (op == 2'd2) ? 0 : 1);
      check({tag, ".drv_data"}, 32'(data), (op == 2'd1) ? 32'(d) : 0);
      check({tag, ".drv_rdy"},  32'(cmd_ready), 0);
      check({tag, ".drv_done"}, 32'(done), 0);
      step();
    end
    check({tag, ".done"},     32'(done), 1);
    check({tag, ".done_en"},  32'(enable), 0);
    check({tag, ".done_rdy"}, 32'(cmd_ready), 0);
    check({tag, ".done_bsy"}, 32'(busy), 1);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                         input logic [LW-1:0] len);
    int n;
    n = (op == 2'd1 || op == 2'd3) ? 1 : (op == 2'd2) ? int'(len) : 0;
    check({tag, ".rdy0"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
    step();
    // Scramble fields after accept: the DUT must have latched them.
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = W'($urandom); cmd_len = LW'($urandom);
    drive_cycles(tag, op, d, n);
    step();
    ref_apply(op, d, len);
    check_idle(tag);
  endtask

  initial begin
    logic [1:0]    rop;
    logic [W-1:0]  rd;
    logic [LW-1:0] rl;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    force_en = 1'b0; force_val = '0;
    step(); step();
    check("reset.ready", 32'(cmd_ready), 1);
    check("reset.en",    32'(enable), 0);
    check("reset.ld",    32'(load), 0);
    check("reset.data",  32'(data), 0);
    check("reset.busy",  32'(busy), 0);
    check("reset.done",  32'(done), 0);
    check("reset.wrap",  32'(wrap_cnt), 0);
    check("reset.err",   32'(err), 0);
    rst_n = 1'b1;
    step();

    // 1: LOAD A
    run_cmd("load_a", 2'd1, 4'hA, 8'd0);
    // 2: LOAD E then RUN 3 -> one wrap
    run_cmd("load_e", 2'd1, 4'hE, 8'd0);
    run_cmd("run3", 2'd2, 4'h0, 8'd3);
    check("run3.wrap1", 32'(wrap_cnt), 1);
    // 3: RUN 0 and NOP
    run_cmd("run0", 2'd2, 4'h5, 8'd0);
    run_cmd("nop", 2'd0, 4'h9, 8'd7);
    // CLEAR from a nonzero count is not a wrap
    run_cmd("load_f", 2'd1, 4'hF, 8'd0);
    run_cmd("clear", 2'd3, 4'h6, 8'd0);

    // 4: valid held high during RUN 5; second command waits for IDLE
    check("hold.rdy0", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 8'd5; cmd_data = '0;
    step();
    cmd_op = 2'd1; cmd_data = 4'h7;
    drive_cycles("hold_run", 2'd2, 4'h0, 5);
    step();
    ref_apply(2'd2, 4'h0, 8'd5);
    check_idle("hold_gap");
    step();
    cmd_valid = 1'b0;
    drive_cycles("hold_load", 2'd1, 4'h7, 1);
    step();
    ref_apply(2'd1, 4'h7, 8'd0);
    check_idle("hold_end");

    // Random command stream
    for (int k = 0; k < 25; k++) begin
      rop = 2'($urandom);
      rd  = W'($urandom);
      rl  = LW'($urandom_range(0, 40));
      run_cmd("rand", rop, rd, rl);
    end

    // Long runs to reach and hold wrap saturation
    for (int k = 0; k < 18; k++) run_cmd("sat", 2'd2, 4'h0, 8'd255);
    check("sat.wrap", 32'(wrap_cnt), 255);

    // 5: reset in the middle of RUN 10
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 8'd10;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    check("midrst.pre_en", 32'(enable), 1);
    rst_n = 1'b0;
    #1;
    check("midrst.en",    32'(enable), 0);
    check("midrst.data",  32'(data), 0);
    check("midrst.busy",  32'(busy), 0);
    check("midrst.done",  32'(done), 0);
    check("midrst.ready", 32'(cmd_ready), 1);
    check("midrst.wrap",  32'(wrap_cnt), 0);
    ref_count = 0; ref_wraps = 0; exp_err = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("midrst.nodone", 32'(done), 0);
    end
    rst_n = 1'b1;
    step();
    check_idle("post_rst");
    run_cmd("post_rst_run", 2'd2, 4'h0, 8'd20);

`ifdef COUNTER_CHECK_EN
    // 6: corrupt the returned count and expect a sticky error
    run_cmd("chk_load2", 2'd1, 4'h2, 8'd0);
    check("chk.clean", 32'(err), 0);
    force_en = 1'b1; force_val = 4'h3;
    step();
    force_en = 1'b0;
    exp_err = 1'b1;
    check("chk.err_set", 32'(err), 1);
    step(); step();
    check("chk.err_sticky", 32'(err), 1);
    run_cmd("chk_after", 2'd2, 4'h0, 8'd4);
    rst_n = 1'b0;
    #1;
    check("chk.err_rst", 32'(err), 0);
    exp_err = 1'b0; ref_count = 0; ref_wraps = 0;
    step();
    rst_n = 1'b1;
    step();
    check_idle("chk_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_ctrl
